instr_fetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 16 +
 rtl/instr_fetch_unit_if.sv | 26 ++
 rtl/pc_next_logic.sv | 17 +
 rtl/instr_fetch_unit.sv | 119 +++++++++++
 tb/tb_instr_fetch_unit.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        FAULT = 3'd4
    } fetch_state_e;

    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] R15_OFFSET       = 32'd8;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory request/response channel between fetch unit and memory.
interface instr_fetch_unit_if;

    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemReady;
    logic        ImemRvalid;
    logic [31:0] ImemRdata;

    modport master (
        output ImemReq,
        output ImemAddr,
        input  ImemReady,
        input  ImemRvalid,
        input  ImemRdata
    );

    modport slave (
        input  ImemReq,
        input  ImemAddr,
        output ImemReady,
        output ImemRvalid,
        output ImemRdata
    );

endinterface

// File: rtl/pc_next_logic.sv
// Next-PC selection, branch target alignment check and R15 read value.
module pc_next_logic
    import fetch_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic        pc_src_i,
    input  logic [31:0] result_i,
    output logic [31:0] pc_next_o,
    output logic        misaligned_o,
    output logic [31:0] pc_plus8_o
);

    assign pc_next_o    = pc_src_i ? result_i : (pc_i + PC_STEP);
    assign misaligned_o = pc_src_i && (result_i[1:0] != 2'b00);
    assign pc_plus8_o   = pc_i + R15_OFFSET;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, fetches one word per step and holds it until retired.
//
// state | meaning
// IDLE  | first cycle after reset release
// REQ   | request driven, waiting for memory to accept
// WAIT  | accepted, waiting for read data (bounded by TIMEOUT)
// HOLD  | instruction presented and held until Advance
// FAULT | sticky fault (timeout or misaligned target), exits only on reset
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      PCSrc,
    input  logic [31:0]               Result,
    input  logic                      Advance,
    instr_fetch_unit_if.master        imem,
    output logic [31:0]               Instr,
    output logic                      InstrValid,
    output logic [31:0]               PC,
    output logic [31:0]               PCPlus8,
    output logic [31:0]               InstrCount,
    output logic                      FetchFault
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  instr_count_q, instr_count_d;
    logic [7:0]   wait_cnt_q, wait_cnt_d;

    logic [31:0]  pc_next;
    logic         misaligned;

    pc_next_logic u_pc_next (
        .pc_i         (pc_q),
        .pc_src_i     (PCSrc),
        .result_i     (Result),
        .pc_next_o    (pc_next),
        .misaligned_o (misaligned),
        .pc_plus8_o   (PCPlus8)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0;
            instr_count_q <= 32'h0;
            wait_cnt_q    <= 8'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_count_q <= instr_count_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_count_d = instr_count_q;
        wait_cnt_d    = wait_cnt_q;

        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (imem.ImemReady && imem.ImemRvalid) begin
                    instr_d = imem.ImemRdata;
                    state_d = HOLD;
                end else if (imem.ImemReady) begin
                    wait_cnt_d = 8'h0;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (imem.ImemRvalid) begin
                    instr_d = imem.ImemRdata;
                    state_d = HOLD;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                    if (wait_cnt_d == TIMEOUT_CNT) begin
                        state_d = FAULT;
                    end
                end
            end
            HOLD: begin
                if (Advance) begin
                    // The retirement is counted even when the target faults.
                    instr_count_d = instr_count_q + 32'd1;
                    if (misaligned) begin
                        state_d = FAULT;
                    end else begin
                        pc_d    = pc_next;
                        state_d = REQ;
                    end
                end
            end
            FAULT:   state_d = FAULT;
            default: state_d = IDLE;
        endcase
    end

    assign imem.ImemReq  = (state_q == REQ);
    assign imem.ImemAddr = pc_q;
    assign Instr         = instr_q;
    assign InstrValid    = (state_q == HOLD);
    assign PC            = pc_q;
    assign InstrCount    = instr_count_q;
    assign FetchFault    = (state_q == FAULT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scenario bench for instr_fetch_unit with a scoreboard of fetched words.
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic        pc_src;
    logic [31:0] result;
    logic        advance;
    logic [31:0] instr, pc, pc_plus8, instr_count;
    logic        instr_valid, fetch_fault;

    logic        adv2;
    logic [31:0] instr2, pc2, pc_plus8_2, instr_count2;
    logic        instr_valid2, fetch_fault2;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t sb_q[$];

    instr_fetch_unit_if imem_if ();
    instr_fetch_unit_if imem_if2 ();

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .PCSrc      (pc_src),
        .Result     (result),
        .Advance    (advance),
        .imem       (imem_if),
        .Instr      (instr),
        .InstrValid (instr_valid),
        .PC         (pc),
        .PCPlus8    (pc_plus8),
        .InstrCount (instr_count),
        .FetchFault (fetch_fault)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT(16)) dut2 (
        .clk        (clk),
        .reset_n    (reset_n),
        .PCSrc      (1'b0),
        .Result     (32'h0),
        .Advance    (adv2),
        .imem       (imem_if2),
        .Instr      (instr2),
        .InstrValid (instr_valid2),
        .PC         (pc2),
        .PCPlus8    (pc_plus8_2),
        .InstrCount (instr_count2),
        .FetchFault (fetch_fault2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return (addr == 32'h0) ? 32'hE280_1001 : (32'hE3A0_0000 | addr);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        pc_src = 1'b0; result = 32'h0; advance = 1'b0; adv2 = 1'b0;
        imem_if.ImemReady = 1'b0; imem_if.ImemRvalid = 1'b0; imem_if.ImemRdata = 32'h0;
        sb_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Serves one fetch at exp_addr; ready after rdy_dly REQ cycles, rvalid rv_dly cycles after ready.
    task automatic fetch(input logic [31:0] exp_addr, input int rdy_dly, input int rv_dly,
                         output int req_cycles);
        exp_t e;
        int   n;
        logic [31:0] data;
        data = mem_word(exp_addr);
        req_cycles = 0;
        n = 0;
        while (imem_if.ImemReq !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (imem_if.ImemReq !== 1'b1) begin
            bad++;
            $display("FAIL req_wait: got ImemReq=%b want 1 within 20 cycles", imem_if.ImemReq);
            return;
        end
        if (imem_if.ImemAddr !== exp_addr) begin
            total++; bad++;
            $display("FAIL imem_addr: got %h want %h", imem_if.ImemAddr, exp_addr);
        end
        req_cycles = 1;
        imem_if.ImemReady = 1'b0;
        for (int i = 0; i < rdy_dly; i++) begin
            @(negedge clk);
            if (imem_if.ImemReq === 1'b1 && imem_if.ImemAddr === exp_addr) req_cycles++;
        end
        imem_if.ImemReady  = 1'b1;
        imem_if.ImemRvalid = (rv_dly == 0);
        imem_if.ImemRdata  = (rv_dly == 0) ? data : 32'hDEAD_BEEF;
        e.pc = exp_addr; e.instr = data;
        sb_q.push_back(e);
        @(negedge clk);
        imem_if.ImemReady  = 1'b0;
        imem_if.ImemRvalid = 1'b0;
        imem_if.ImemRdata  = 32'hDEAD_BEEF;
        if (rv_dly > 0) begin
            for (int i = 0; i < rv_dly - 1; i++) @(negedge clk);
            chk("valid_before_rvalid", {31'b0, instr_valid}, 32'd0);
            imem_if.ImemRvalid = 1'b1;
            imem_if.ImemRdata  = data;
            @(negedge clk);
            imem_if.ImemRvalid = 1'b0;
            imem_if.ImemRdata  = 32'hDEAD_BEEF;
        end
        chk("hold_valid", {31'b0, instr_valid}, 32'd1);
        e = sb_q.pop_front();
        chk("hold_instr", instr, e.instr);
        chk("hold_pc", pc, e.pc);
    endtask

    task automatic do_advance(input logic src, input logic [31:0] target);
        pc_src = src; result = target; advance = 1'b1;
        @(negedge clk);
        advance = 1'b0; pc_src = 1'b0; result = 32'h0;
    endtask

    task automatic test_reset();
        do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_instr", instr, 32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_req", {31'b0, imem_if.ImemReq}, 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_count", instr_count, 32'h0);
        chk("rst_fault", {31'b0, fetch_fault}, 32'd0);
        reset_n = 1'b1;
        #1;
        chk("idle_req", {31'b0, imem_if.ImemReq}, 32'd0);
        @(negedge clk);
        chk("req_after_idle", {31'b0, imem_if.ImemReq}, 32'd1);
    endtask

    task automatic test_zero_wait();
        int rc;
        fetch(32'h0, 0, 0, rc);
        chk("pc_plus8", pc_plus8, 32'h8);
        do_advance(1'b0, 32'h0);
        chk("valid_gap0", {31'b0, instr_valid}, 32'd0);
        fetch(32'h4, 0, 0, rc);
        do_advance(1'b0, 32'h0);
        chk("valid_gap1", {31'b0, instr_valid}, 32'd0);
        fetch(32'h8, 0, 0, rc);
        chk("count_seq", instr_count, 32'd2);
    endtask

    task automatic test_branch();
        int rc;
        do_advance(1'b1, 32'h40);
        chk("branch_count", instr_count, 32'd3);
        fetch(32'h40, 0, 0, rc);
    endtask

    task automatic test_wait_states();
        int rc;
        do_advance(1'b0, 32'h0);
        fetch(32'h44, 3, 2, rc);
        chk("req_cycles", rc, 32'd4);
    endtask

    task automatic test_misaligned();
        do_advance(1'b1, 32'h42);
        chk("mis_fault", {31'b0, fetch_fault}, 32'd1);
        chk("mis_pc", pc, 32'h44);
        chk("mis_count", instr_count, 32'd5);
        chk("mis_valid", {31'b0, instr_valid}, 32'd0);
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        n = 0;
        while (imem_if.ImemReq !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("to_req", {31'b0, imem_if.ImemReq}, 32'd1);
        imem_if.ImemReady = 1'b1;
        @(negedge clk);
        imem_if.ImemReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("to_nofault%0d", i), {31'b0, fetch_fault}, 32'd0);
            @(negedge clk);
        end
        chk("to_fault", {31'b0, fetch_fault}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            imem_if.ImemRvalid = 1'b1;
            imem_if.ImemReady  = 1'b1;
            @(negedge clk);
            chk("to_sticky_req", {31'b0, imem_if.ImemReq}, 32'd0);
            chk("to_sticky_valid", {31'b0, instr_valid}, 32'd0);
            chk("to_sticky_fault", {31'b0, fetch_fault}, 32'd1);
        end
        imem_if.ImemRvalid = 1'b0;
        imem_if.ImemReady  = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        int rc;
        do_reset();
        fetch(32'h0, 0, 0, rc);
        do_advance(1'b0, 32'h0);
        imem_if.ImemReady = 1'b1;
        @(negedge clk);
        imem_if.ImemReady = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        imem_if.ImemRvalid = 1'b1;
        imem_if.ImemRdata  = 32'h1234_5678;
        #1;
        chk("mid_rst_instr", instr, 32'h0);
        chk("mid_rst_pc", pc, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        imem_if.ImemRvalid = 1'b0;
        chk("stale_instr", instr, 32'h0);
        chk("stale_pc", pc, 32'h0);
        chk("stale_valid", {31'b0, instr_valid}, 32'd0);
        fetch(32'h0, 0, 0, rc);
    endtask

    task automatic test_count_wrap();
        force dut.instr_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.instr_count_q;
        #1;
        chk("cnt_preload", instr_count, 32'hFFFF_FFFF);
        do_advance(1'b0, 32'h0);
        chk("cnt_wrap", instr_count, 32'h0);
        chk("cnt_wrap_fault", {31'b0, fetch_fault}, 32'd0);
    endtask

    task automatic test_pc_wrap();
        do_reset();
        repeat (2) @(negedge clk);
        chk("wrap_valid", {31'b0, instr_valid2}, 32'd1);
        chk("wrap_pc", pc2, 32'hFFFF_FFFC);
        chk("wrap_pc8", pc_plus8_2, 32'h4);
        chk("wrap_instr", instr2, 32'hE1A0_0000);
        adv2 = 1'b1;
        @(negedge clk);
        adv2 = 1'b0;
        chk("wrap_pc_next", pc2, 32'h0);
        chk("wrap_fault", {31'b0, fetch_fault2}, 32'd0);
        chk("wrap_count", instr_count2, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        pc_src = 1'b0; result = 32'h0; advance = 1'b0; adv2 = 1'b0;
        imem_if.ImemReady = 1'b0; imem_if.ImemRvalid = 1'b0; imem_if.ImemRdata = 32'h0;
        imem_if2.ImemReady = 1'b1; imem_if2.ImemRvalid = 1'b1; imem_if2.ImemRdata = 32'hE1A0_0000;
        test_reset();
        test_zero_wait();
        test_branch();
        test_wait_states();
        test_misaligned();
        test_timeout();
        test_reset_mid_wait();
        test_count_wrap();
        test_pc_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
